// File: rtl/countdown_fsm_if.sv
// ----------------------------------------------------------------------------
// countdown_fsm_if
//
// Purpose : carries the two trigger outputs of countdown_fsm, one from the
//           registered (Moore) variant and one from the combinational (Mealy)
//           variant, so a consumer can pick either or compare them.
//
// Signals :
//   trigger_moore  1  sticky "countdown expired" flag, registered output path
//   trigger_mealy  1  same waveform, decoded combinationally from state and rst
//
// Modports:
//   master  driven by countdown_fsm
//   slave   observed by downstream logic
// ----------------------------------------------------------------------------
interface countdown_fsm_if;
    logic trigger_moore;
    logic trigger_mealy;

    modport master (output trigger_moore, output trigger_mealy);
    modport slave  (input  trigger_moore, input  trigger_mealy);
endinterface

// File: rtl/countdown_fsm.sv
// ----------------------------------------------------------------------------
// countdown_fsm
//
// Purpose : post-reset countdown timer. A down-counter is loaded with COUNT on
//           reset and decrements once per rising clk edge, saturating at 0.
//           A sticky trigger asserts after COUNT edges following reset
//           release and stays high until the next reset. Two output styles
//           are provided with identical cycle behaviour:
//             countdown_moore : trigger comes from a flop (done_q)
//             countdown_mealy : trigger = (cnt == 0) & ~rst, combinational
//
// Parameters:
//   COUNT  number of rising clk edges before trigger asserts (legal 1..255)
//
// Ports (countdown_fsm):
//   clk    input   rising-edge clock
//   rst    input   asynchronous active-high reset
//   cd     countdown_fsm_if.master  trigger_moore / trigger_mealy outputs
//
// Optional build macro:
//   COUNTDOWN_CHECK_EN  when defined, both variants compile simulation-only
//                       concurrent assertions (counter range, sticky trigger,
//                       trigger/state consistency) and an elaboration-time
//                       COUNT range check. Function is identical either way.
//
// FSM view (both variants share it; the state register is the counter):
//   state        | meaning
//   S_COUNT(k)   | cnt == k, k = COUNT..1, still counting down
//   S_DONE       | cnt == 0, countdown expired, holds until rst
// ----------------------------------------------------------------------------

// ----------------------------------------------------------------------------
// countdown_moore : registered-output variant.
//   clk, rst  clock and asynchronous active-high reset
//   trigger   = done_q; no combinational path from any input
// ----------------------------------------------------------------------------
module countdown_moore #(
    parameter int COUNT = 4
) (
    input  logic clk,
    input  logic rst,
    output logic trigger
);
    localparam int W = $clog2(COUNT + 1);

    localparam logic [W-1:0] S_LOAD = W'(COUNT);
    localparam logic [W-1:0] S_LAST = W'(1);
    localparam logic [W-1:0] S_DONE = '0;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         done_q;
    logic         done_d;

    always_comb begin
        cnt_d  = cnt_q;
        done_d = done_q;
        if (cnt_q != S_DONE) begin
            cnt_d = cnt_q - W'(1);
        end
        // Set on the same edge that takes the counter from 1 to 0, so the
        // flag lines up with the Mealy decode of cnt == 0.
        if (cnt_q == S_LAST) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= S_LOAD;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign trigger = done_q;

`ifdef COUNTDOWN_CHECK_EN
    if ((COUNT < 1) || (COUNT > 255)) begin : g_count_range_bad
        $error("countdown_moore: COUNT=%0d outside 1..255", COUNT);
    end

    a_cnt_range : assert property (@(posedge clk) cnt_q <= S_LOAD)
        else $error("countdown_moore: cnt_q=%0d exceeds COUNT", cnt_q);

    a_sticky : assert property (@(posedge clk) disable iff (rst) trigger |=> trigger)
        else $error("countdown_moore: trigger fell while rst low");

    a_consistent : assert property (@(negedge clk) disable iff (rst)
                                    trigger == (cnt_q == S_DONE))
        else $error("countdown_moore: trigger disagrees with cnt_q=%0d", cnt_q);
`endif
endmodule

// ----------------------------------------------------------------------------
// countdown_mealy : combinational-output variant.
//   clk, rst  clock and asynchronous active-high reset
//   trigger   = (cnt == 0) & ~rst; rst reaches trigger without a flop
// ----------------------------------------------------------------------------
module countdown_mealy #(
    parameter int COUNT = 4
) (
    input  logic clk,
    input  logic rst,
    output logic trigger
);
    localparam int W = $clog2(COUNT + 1);

    localparam logic [W-1:0] S_LOAD = W'(COUNT);
    localparam logic [W-1:0] S_DONE = '0;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != S_DONE) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= S_LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The ~rst term is redundant once cnt_q has reloaded, but it keeps the
    // output low in the same delta that rst rises, independent of flop timing.
    assign trigger = (cnt_q == S_DONE) & ~rst;

`ifdef COUNTDOWN_CHECK_EN
    if ((COUNT < 1) || (COUNT > 255)) begin : g_count_range_bad
        $error("countdown_mealy: COUNT=%0d outside 1..255", COUNT);
    end

    a_cnt_range : assert property (@(posedge clk) cnt_q <= S_LOAD)
        else $error("countdown_mealy: cnt_q=%0d exceeds COUNT", cnt_q);

    a_sticky : assert property (@(posedge clk) disable iff (rst) trigger |=> trigger)
        else $error("countdown_mealy: trigger fell while rst low");

    a_consistent : assert property (@(negedge clk) disable iff (rst)
                                    trigger == (cnt_q == S_DONE))
        else $error("countdown_mealy: trigger disagrees with cnt_q=%0d", cnt_q);
`endif
endmodule

// ----------------------------------------------------------------------------
// countdown_fsm : top level, both variants side by side on one interface.
// ----------------------------------------------------------------------------
module countdown_fsm #(
    parameter int COUNT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    countdown_fsm_if.master        cd
);
    logic trigger_moore;
    logic trigger_mealy;

    countdown_moore #(.COUNT(COUNT)) u_moore (
        .clk     (clk),
        .rst     (rst),
        .trigger (trigger_moore)
    );

    countdown_mealy #(.COUNT(COUNT)) u_mealy (
        .clk     (clk),
        .rst     (rst),
        .trigger (trigger_mealy)
    );

    assign cd.trigger_moore = trigger_moore;
    assign cd.trigger_mealy = trigger_mealy;
endmodule

// File: tb/tb_countdown_fsm.sv
module tb_countdown_fsm;
    logic clk;
    logic rst;

    int n_total;
    int n_pass;

    countdown_fsm_if if4   ();
    countdown_fsm_if if1   ();
    countdown_fsm_if if255 ();

    countdown_fsm #(.COUNT(4))   dut4   (.clk(clk), .rst(rst), .cd(if4.master));
    countdown_fsm #(.COUNT(1))   dut1   (.clk(clk), .rst(rst), .cd(if1.master));
    countdown_fsm #(.COUNT(255)) dut255 (.clk(clk), .rst(rst), .cd(if255.master));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    endtask

    // Checks both variants of all three instances against expected values.
    task automatic check_all(input string tag, input int edge_n,
                             input logic e4, input logic e1, input logic e255);
        check($sformatf("%s e%0d c4_moore",   tag, edge_n), if4.trigger_moore,   e4);
        check($sformatf("%s e%0d c4_mealy",   tag, edge_n), if4.trigger_mealy,   e4);
        check($sformatf("%s e%0d c1_moore",   tag, edge_n), if1.trigger_moore,   e1);
        check($sformatf("%s e%0d c1_mealy",   tag, edge_n), if1.trigger_mealy,   e1);
        check($sformatf("%s e%0d c255_moore", tag, edge_n), if255.trigger_moore, e255);
        check($sformatf("%s e%0d c255_mealy", tag, edge_n), if255.trigger_mealy, e255);
    endtask

    // One rising edge, then land on the following falling edge for sampling.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Assert rst on a falling edge, confirm outputs drop before the next
    // rising edge, hold through one rising edge, release on the falling edge.
    task automatic reset_pulse(input string tag);
        rst = 1'b1;
        #1;
        check_all(tag, 0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check_all({tag, "_held"}, 0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst     = 1'b0;

        // Power-on reset, held through one rising edge (that edge must not count).
        #2;
        rst = 1'b1;
        #1;
        check_all("reset", 0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check_all("reset_held", 0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Main countdown: COUNT=4 rises after edge 4, COUNT=1 after edge 1,
        // COUNT=255 after edge 255; all sticky, no wrap through edge 270.
        for (int n = 1; n <= 270; n++) begin
            step();
            check_all("run", n, (n >= 4), 1'b1, (n >= 255));
        end

        // Reset after expiry: outputs drop asynchronously, then re-expire.
        reset_pulse("rst_after_exp");
        for (int n = 1; n <= 5; n++) begin
            step();
            check_all("reexp", n, (n >= 4), 1'b1, 1'b0);
        end

        // Reset mid-count: 2 edges in, pulse rst, count restarts from zero.
        reset_pulse("rst_pre");
        for (int n = 1; n <= 2; n++) begin
            step();
            check_all("pre_mid", n, 1'b0, 1'b1, 1'b0);
        end
        reset_pulse("rst_mid");
        for (int n = 1; n <= 6; n++) begin
            step();
            check_all("post_mid", n, (n >= 4), 1'b1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
